// File: rtl/config_pkg.sv
// Shared configuration for the data-memory slice: region bounds, RAM geometry
// and the access-width encoding used on the LSU request port.
package config_pkg;

   localparam logic [31:0] DMemStart     = 32'h0001_0000;
   localparam logic [31:0] DMemSize      = 32'h0000_1000;
   localparam int unsigned DMemAddrWidth = 12;
   localparam int unsigned DMemWords     = DMemSize / 4;

   typedef enum logic [1:0] {
      MW_BYTE = 2'b00,
      MW_HALF = 2'b01,
      MW_WORD = 2'b10,
      MW_RSVD = 2'b11
   } mem_width_t;

   localparam logic [2:0] NBytesByte = 3'd1;
   localparam logic [2:0] NBytesHalf = 3'd2;
   localparam logic [2:0] NBytesWord = 3'd4;

   function automatic logic [2:0] width_bytes(mem_width_t w);
      case (w)
         MW_BYTE: width_bytes = NBytesByte;
         MW_HALF: width_bytes = NBytesHalf;
         MW_WORD: width_bytes = NBytesWord;
         default: width_bytes = 3'd0;
      endcase
   endfunction

   function automatic logic [3:0] width_mask(mem_width_t w);
      case (w)
         MW_BYTE: width_mask = 4'b0001;
         MW_HALF: width_mask = 4'b0011;
         MW_WORD: width_mask = 4'b1111;
         default: width_mask = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port 32-bit data RAM with per-byte write enables and a registered read.
module dmem_ram
   import config_pkg::*;
#(
   parameter int unsigned Depth     = DMemWords,
   parameter int unsigned AddrWidth = DMemAddrWidth - 2
) (
   input  logic                 clk,
   input  logic                 en,
   input  logic [3:0]           be,
   input  logic [AddrWidth-1:0] addr,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata
);

   logic [31:0] mem [Depth];

   always_ff @(posedge clk) begin
      if (en) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit for the DMem region: range check, two-word split accesses,
// byte-lane steering for stores and extraction/extension for loads.
module dmem_lsu
   import config_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  width,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic        resp_valid,
   output logic [31:0] rdata,
   output logic        fault
);

   typedef enum logic [1:0] {ST_IDLE, ST_W0, ST_W1, ST_RESP} state_t;

   state_t     state, state_nxt;
   logic       we_q, sext_q, fault_q;
   mem_width_t width_q;
   logic [DMemAddrWidth-1:0] off_q;
   logic [31:0] wdata_q, w0_q;

   logic        accept, req_fault, split;
   logic [31:0] off;
   logic [32:0] end_off;
   logic [1:0]  lane;
   logic [2:0]  n_q;

   logic        ram_en;
   logic [3:0]  ram_be;
   logic [DMemAddrWidth-3:0] ram_addr;
   logic [31:0] ram_wdata, ram_rdata;

   logic [31:0] word0, ld_word;
   logic [55:0] ld_cat;

   assign ready  = (state == ST_IDLE);
   assign accept = req && ready;

   // 33-bit end offset so an access straddling the top of the address space cannot wrap back in.
   assign off       = addr - DMemStart;
   assign end_off   = {1'b0, off} + {30'b0, width_bytes(mem_width_t'(width))};
   assign req_fault = (mem_width_t'(width) == MW_RSVD) || (addr < DMemStart) ||
                      (end_off > {1'b0, DMemSize});

   assign lane  = off_q[1:0];
   assign n_q   = width_bytes(width_q);
   assign split = ({1'b0, lane} + n_q) > 3'd4;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = req_fault ? ST_RESP : ST_W0;
         ST_W0:   state_nxt = split ? ST_W1 : ST_RESP;
         ST_W1:   state_nxt = ST_RESP;
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         we_q    <= 1'b0;
         width_q <= MW_BYTE;
         sext_q  <= 1'b0;
         off_q   <= '0;
         wdata_q <= '0;
         fault_q <= 1'b0;
         w0_q    <= '0;
      end else begin
         if (accept) begin
            we_q    <= we;
            width_q <= mem_width_t'(width);
            sext_q  <= sign_ext;
            off_q   <= off[DMemAddrWidth-1:0];
            wdata_q <= wdata;
            fault_q <= req_fault;
         end
         if (state == ST_W1) w0_q <= ram_rdata;
      end
   end

   // W0 carries the low lanes of the access; W1 carries whatever spilled past lane 3.
   always_comb begin
      ram_en    = 1'b0;
      ram_be    = '0;
      ram_addr  = off_q[DMemAddrWidth-1:2];
      ram_wdata = '0;
      if (state == ST_W0) begin
         ram_en    = 1'b1;
         ram_wdata = wdata_q << {lane, 3'b000};
         if (we_q) ram_be = width_mask(width_q) << lane;
      end else if (state == ST_W1) begin
         ram_en    = 1'b1;
         ram_addr  = off_q[DMemAddrWidth-1:2] + 1'b1;
         ram_wdata = wdata_q >> (6'd32 - {1'b0, lane, 3'b000});
         if (we_q) ram_be = width_mask(width_q) >> (3'd4 - {1'b0, lane});
      end
   end

   dmem_ram #(
      .Depth    (DMemWords),
      .AddrWidth(DMemAddrWidth - 2)
   ) u_ram (
      .clk  (clk),
      .en   (ram_en),
      .be   (ram_be),
      .addr (ram_addr),
      .wdata(ram_wdata),
      .rdata(ram_rdata)
   );

   // Single-word loads see word0 straight from the RAM in RESP; split loads use the copy taken in W1.
   assign word0  = split ? w0_q : ram_rdata;
   assign ld_cat = {ram_rdata[23:0], word0};

   always_comb begin
      ld_word = '0;
      case (lane)
         2'd0: ld_word = ld_cat[31:0];
         2'd1: ld_word = ld_cat[39:8];
         2'd2: ld_word = ld_cat[47:16];
         2'd3: ld_word = ld_cat[55:24];
         default: ld_word = '0;
      endcase
   end

   always_comb begin
      resp_valid = (state == ST_RESP);
      fault      = resp_valid && fault_q;
      rdata      = '0;
      if (resp_valid && !fault_q && !we_q) begin
         case (width_q)
            MW_BYTE: rdata = {{24{sext_q & ld_word[7]}}, ld_word[7:0]};
            MW_HALF: rdata = {{16{sext_q & ld_word[15]}}, ld_word[15:0]};
            default: rdata = ld_word;
         endcase
      end
   end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-003 req  in  1  request valid; accepted only when req && ready.
REQ-004 we  in  1  1 = store, 0 = load.
REQ-005 width  in  2  mem_width_t: 00 byte, 01 half, 10 word, 11 reserved.
REQ-006 sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-007 addr  in  32  byte address; little-endian.
REQ-008 wdata  in  32  store data, right-aligned (bits [8n-1:0] used).
REQ-009 ready  out  1  high only in IDLE.
REQ-010 resp_valid  out  1  one-cycle completion pulse for every accepted request.
REQ-011 rdata  out  32  load result; valid only with resp_valid on a non-faulting load, else 0.
REQ-012 fault  out  1  valid with resp_valid; 1 = rejected request, no memory effect.

Function
REQ-013 The block SHALL own the DMem region [DMemStart, DMemStart+DMemSize) from config_pkg, held in an internal RAM of DMemSize/4 32-bit words.
REQ-014 n = 1/2/4 bytes for width 00/01/10; off = addr - DMemStart, computed in 32 bits.
REQ-015 fault SHALL be set when width = 11, addr < DMemStart, or off+n > DMemSize (no wrap-around into or out of the region).
REQ-016 Accept cycle T: latch we, width, sign_ext, off, wdata; go to RESP if faulting, else W0.
REQ-017 States IDLE, W0, W1, RESP; W0 accesses word off[..:2]; W1 (entered only when off[1:0]+n > 4) accesses the next word; RESP pulses resp_valid, then IDLE.
REQ-018 Latency from accept: fault -> resp at T+1; single-word -> T+2; split -> T+3; stores and loads identical.
REQ-019 Stores SHALL write only lanes covered by the access: W0 lanes off[1:0]..min(3,off[1:0]+n-1); W1 lanes 0..off[1:0]+n-5.
REQ-020 RAM read latency is one cycle; word0 read data SHALL be registered in the cycle after W0; word1 data used directly in RESP.
REQ-021 Loads: extract n bytes starting at lane off[1:0] across {word1,word0}, extend per sign_ext to 32 bits.
REQ-022 req while ready = 0 SHALL be ignored with no side effect; inputs other than req are don't-care outside the accept cycle.
REQ-023 A faulting store SHALL leave all RAM contents unchanged.

Reset
REQ-024 On reset_n low: state IDLE, ready 1 after release, resp_valid 0, fault 0, rdata 0, request registers 0.
REQ-025 Reset mid-operation SHALL abort the request without resp_valid; a split store interrupted in W1 leaves word1 unwritten (word0 may already be written).
REQ-026 RAM contents are not reset.

Structure
REQ-027 mem_width_t enum and width-to-byte-count constants SHALL live in config_pkg next to DMemStart/DMemSize/DMemAddrWidth.
REQ-028 Storage SHALL be a sub-module dmem_ram: one port, 32-bit, 4-bit byte write enable, synchronous read, depth DMemSize/4.
REQ-029 FSM, range check, lane steering and extension reside in dmem_lsu.

Verification (DMemStart 0x0001_0000, DMemSize 0x1000)
REQ-030 Store word 0xDEADBEEF @0x0001_0010 (resp T+2, fault 0); load word same addr -> rdata 0xDEADBEEF at T+2.
REQ-031 After REQ-030: load byte @0x0001_0013 sign_ext=1 -> 0xFFFFFFDE; sign_ext=0 -> 0x000000DE; load half @0x0001_0012 sign_ext=1 -> 0xFFFFDEAD.
REQ-032 Store word 0x11223344 @0x0001_0022 -> resp T+3; load word @0x0001_0022 -> 0x11223344 at T+3; load byte @0x0001_0021 unchanged from prior contents.
REQ-033 Load word @0x0001_0FFE, store @0x0000_FFFC, width=11 @0x0001_0000 -> each fault=1 at T+1, rdata 0, RAM unchanged.
REQ-034 req held high during W0/W1/RESP -> exactly one response; next accept no earlier than the cycle after RESP.
REQ-035 reset_n low during W1 of split store @0x0001_0032 -> no resp_valid, outputs 0, word @0x0001_0034 unchanged, ready 1 after release.
